// File: rtl/serial_pe_pkg.sv
// Shared widths, ctl bit indices and the operand bundle for the serial_pe
// multiply-accumulate processing element.
package serial_pe_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 45;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned CTL_W  = 2;
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam int unsigned CTL_FIRST = 0;
    localparam int unsigned CTL_LAST  = 1;

    // One element's worth of operands and framing as seen by the multiplier.
    typedef struct packed {
        logic [DATA_W-1:0] neuron;
        logic [DATA_W-1:0] weight;
        logic [CTL_W-1:0]  ctl;
        logic              vld;
    } pe_in_t;

    // Sign-extend a full-precision product to the accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/serial_pe_mac.sv
// Signed 16x16 multiplier feeding a 45-bit load/accumulate register.
// acc is the running sum including this cycle's product, so a caller can
// capture the finished dot product on the same edge the register updates.
module serial_pe_mac
    import serial_pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [RES_W-1:0]  acc
);

    logic signed [PROD_W-1:0] prod_c;
    logic [ACC_W-1:0]         prod_ext_c;
    logic [ACC_W-1:0]         acc_d;
    logic [ACC_W-1:0]         acc_q;

    assign prod_c     = PROD_W'($signed(a)) * PROD_W'($signed(b));
    assign prod_ext_c = sext_prod(prod_c);

    // load restarts the sum with this product; otherwise wrap-around accumulate.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = load ? prod_ext_c : acc_q + prod_ext_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_d[RES_W-1:0];

endmodule

// File: rtl/serial_pe.sv
// Serial MAC processing element: optional input register, MAC, result register.
// Define SERIAL_PE_IN_REG_EN to register operands before the multiplier (latency 2).
module serial_pe
    import serial_pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] neuron,
    input  logic [DATA_W-1:0] weight,
    input  logic [CTL_W-1:0]  ctl,
    input  logic              vld_i,
    output logic [RES_W-1:0]  result,
    output logic              vld_o
);

    pe_in_t            in_c;
    pe_in_t            stg_c;
    logic [RES_W-1:0]  sum_c;
    logic              end_c;
    logic [RES_W-1:0]  result_d;
    logic [RES_W-1:0]  result_q;
    logic              vld_o_d;
    logic              vld_o_q;

    assign in_c = '{neuron: neuron, weight: weight, ctl: ctl, vld: vld_i};

`ifdef SERIAL_PE_IN_REG_EN
    pe_in_t in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= in_c;
        end
    end

    assign stg_c = in_q;
`else
    assign stg_c = in_c;
`endif

    serial_pe_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stg_c.vld),
        .load  (stg_c.ctl[CTL_FIRST]),
        .a     (stg_c.neuron),
        .b     (stg_c.weight),
        .acc   (sum_c)
    );

    // Capture the final sum on the vector's last element; result holds otherwise.
    assign end_c = stg_c.vld & stg_c.ctl[CTL_LAST];

    always_comb begin
        result_d = result_q;
        vld_o_d  = end_c;
        if (end_c) begin
            result_d = sum_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            vld_o_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            vld_o_q  <= vld_o_d;
        end
    end

    assign result = result_q;
    assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_serial_pe.sv
// Randomized self-checking bench for serial_pe; expected dot products are
// computed directly from the operand lists with 64-bit arithmetic.
module tb_serial_pe;

`ifdef SERIAL_PE_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] neuron;
    logic [15:0] weight;
    logic [1:0]  ctl;
    logic        vld_i;
    logic [31:0] result;
    logic        vld_o;

    int tests;
    int fails;
    int unsigned cyc;
    int unsigned last_cyc;

    logic [31:0] obs_res[$];
    int unsigned obs_cyc[$];

    logic [15:0] vn[$];
    logic [15:0] vw[$];

    serial_pe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .result (result),
        .vld_o  (vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every result strobe with the cycle it appeared in.
    always @(negedge clk) begin
        if (vld_o) begin
            obs_res.push_back(result);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [15:0] n, input logic [15:0] w,
                        input logic [1:0] c, input logic v);
        @(negedge clk);
        neuron   = n;
        weight   = w;
        ctl      = c;
        vld_i    = v;
        last_cyc = cyc;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            send(16'($urandom), 16'($urandom), 2'($urandom), 1'b0);
        end
    endtask

    // Stream vn/vw as one framed vector with no bubbles.
    task automatic send_vec();
        for (int i = 0; i < vn.size(); i++) begin
            send(vn[i], vw[i], {(i == vn.size() - 1), (i == 0)}, 1'b1);
        end
    endtask

    function automatic logic [31:0] dot();
        longint s;
        s = 0;
        for (int i = 0; i < vn.size(); i++) begin
            s += longint'($signed(vn[i])) * longint'($signed(vw[i]));
        end
        return s[31:0];
    endfunction

    task automatic fill(input int len, input bit rnd,
                        input logic [15:0] n, input logic [15:0] w);
        vn.delete();
        vw.delete();
        for (int i = 0; i < len; i++) begin
            vn.push_back(rnd ? 16'($urandom) : n);
            vw.push_back(rnd ? 16'($urandom) : w);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        neuron = '0;
        weight = '0;
        ctl    = '0;
        vld_i  = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (result !== 32'h0) begin
            fails++;
            $display("FAIL reset_result: got %h want %h", result, 32'h0);
        end
        tests++;
        if (vld_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_vld_o: got %b want 0", vld_o);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_const(input string name, input logic [15:0] n,
                              input logic [15:0] w, input logic [31:0] want);
        int unsigned due;
        obs_res.delete();
        obs_cyc.delete();
        fill(32, 1'b0, n, w);
        send_vec();
        due = last_cyc + LAT;
        idle(LAT + 3);
        tests++;
        if (obs_res.size() != 1) begin
            fails++;
            $display("FAIL %s_pulses: got %0d want 1", name, obs_res.size());
        end else begin
            tests++;
            if (obs_res[0] !== want) begin
                fails++;
                $display("FAIL %s_result: got %h want %h", name, obs_res[0], want);
            end
            tests++;
            if (obs_cyc[0] != due) begin
                fails++;
                $display("FAIL %s_latency: got cycle %0d want %0d", name, obs_cyc[0], due);
            end
        end
        tests++;
        if (result !== want) begin
            fails++;
            $display("FAIL %s_hold: got %h want %h", name, result, want);
        end
    endtask

    task automatic test_len1();
        logic [31:0] want[$];
        int unsigned first_due;
        obs_res.delete();
        obs_cyc.delete();
        fill(1, 1'b0, 16'h8000, 16'h8000);
        want.push_back(dot());
        send_vec();
        first_due = last_cyc + LAT;
        for (int k = 0; k < 3; k++) begin
            fill(1, 1'b1, 16'h0, 16'h0);
            want.push_back(dot());
            send_vec();
        end
        idle(LAT + 3);
        tests++;
        if (want[0] !== 32'h4000_0000) begin
            fails++;
            $display("FAIL len1_model: got %h want %h", want[0], 32'h4000_0000);
        end
        tests++;
        if (obs_res.size() != 4) begin
            fails++;
            $display("FAIL len1_pulses: got %0d want 4", obs_res.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (obs_res[k] !== want[k] || obs_cyc[k] != first_due + k) begin
                    fails++;
                    $display("FAIL len1_vec%0d: got %h@%0d want %h@%0d",
                             k, obs_res[k], obs_cyc[k], want[k], first_due + k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want[$];
        int unsigned due[$];
        obs_res.delete();
        obs_cyc.delete();
        for (int k = 1; k <= 4; k++) begin
            fill(32 * k, 1'b1, 16'h0, 16'h0);
            want.push_back(dot());
            send_vec();
            due.push_back(last_cyc + LAT);
        end
        idle(LAT + 3);
        tests++;
        if (obs_res.size() != 4) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d want 4", obs_res.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (obs_res[k] !== want[k] || obs_cyc[k] != due[k]) begin
                    fails++;
                    $display("FAIL b2b_vec%0d: got %h@%0d want %h@%0d",
                             k, obs_res[k], obs_cyc[k], want[k], due[k]);
                end
            end
        end
    endtask

    task automatic test_gap();
        logic [31:0] want;
        obs_res.delete();
        obs_cyc.delete();
        fill(24, 1'b1, 16'h0, 16'h0);
        want = dot();
        send_vec();
        for (int i = 0; i < vn.size(); i++) begin
            send(vn[i], vw[i], {(i == vn.size() - 1), (i == 0)}, 1'b1);
            if (i == 11) idle(5);
        end
        idle(LAT + 3);
        tests++;
        if (obs_res.size() != 2) begin
            fails++;
            $display("FAIL gap_pulses: got %0d want 2", obs_res.size());
        end else begin
            tests++;
            if (obs_res[0] !== want) begin
                fails++;
                $display("FAIL gap_nogap_result: got %h want %h", obs_res[0], want);
            end
            tests++;
            if (obs_res[1] !== want) begin
                fails++;
                $display("FAIL gap_result: got %h want %h", obs_res[1], want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] want;
        obs_res.delete();
        obs_cyc.delete();
        fill(40, 1'b1, 16'h0, 16'h0);
        for (int i = 0; i < 15; i++) begin
            send(vn[i], vw[i], {1'b0, (i == 0)}, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (result !== 32'h0 || vld_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: got %h/%b want 00000000/0", result, vld_o);
        end
        vld_i = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        fill(40, 1'b1, 16'h0, 16'h0);
        want = dot();
        send_vec();
        idle(LAT + 3);
        tests++;
        if (obs_res.size() != 1) begin
            fails++;
            $display("FAIL rstmid_pulses: got %0d want 1", obs_res.size());
        end else begin
            tests++;
            if (obs_res[0] !== want) begin
                fails++;
                $display("FAIL rstmid_result: got %h want %h", obs_res[0], want);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_const("ones", 16'h0001, 16'h0002, 32'h0000_0040);
        test_const("signed", 16'hFFFF, 16'h0003, 32'hFFFF_FFA0);
        test_len1();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
